// File: rtl/cla_pkg.sv
// Shared types, widths and carry-lookahead helper functions for the
// carry-lookahead accumulator and its adder.
package cla_pkg;

  localparam int DATA_W  = 16;
  localparam int CARRY_W = 4;
  localparam int GROUP_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Carries 1..3 of a 4-bit lookahead block, fully expanded from cin.
  function automatic logic [2:0] laInner(input logic [3:0] g, input logic [3:0] p,
                                         input logic cin);
    logic c1, c2, c3;
    c1 = g[0] | (p[0] & cin);
    c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    return {c3, c2, c1};
  endfunction

  function automatic logic laGen(input logic [3:0] g, input logic [3:0] p);
    return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  endfunction

endpackage

// File: rtl/cla_accumulator_adder.sv
// Two-level 16-bit carry-lookahead adder: four 4-bit blocks whose
// group carries come from a second lookahead stage.
module CLA_Adder_dat
  import cla_pkg::*;
(
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic              C_In,
  output logic [DATA_W-1:0] Sum,
  output logic              C_Out
);

  localparam int GROUPS = DATA_W / GROUP_W;

  logic [DATA_W-1:0] gen;
  logic [DATA_W-1:0] prop;
  logic [DATA_W-1:0] carries;
  logic [GROUPS-1:0] groupG;
  logic [GROUPS-1:0] groupP;
  logic [GROUPS-1:0] groupCin;
  logic [GROUPS:1]   groupC;

  assign gen  = A & B;
  assign prop = A ^ B;

  for (genvar k = 0; k < GROUPS; k++) begin : gBlock
    assign groupG[k] = laGen(gen[GROUP_W*k +: GROUP_W], prop[GROUP_W*k +: GROUP_W]);
    assign groupP[k] = &prop[GROUP_W*k +: GROUP_W];
    assign carries[GROUP_W*k] = groupCin[k];
    assign carries[GROUP_W*k+1 +: 3] = laInner(gen[GROUP_W*k +: GROUP_W],
                                               prop[GROUP_W*k +: GROUP_W], groupCin[k]);
  end

  // Second-level lookahead produces every block carry-in directly from C_In.
  assign groupC[3:1] = laInner(groupG, groupP, C_In);
  assign groupC[4]   = laGen(groupG, groupP) | (&groupP & C_In);
  assign groupCin    = {groupC[3:1], C_In};

  assign Sum   = prop ^ carries;
  assign C_Out = groupC[4];

endmodule

// File: rtl/cla_accumulator.sv
// Groups incoming 16-bit beats, accumulates them through the CLA adder and
// presents sum, carry-out count and beat count once the last beat arrives.
module cla_accumulator
  import cla_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [DATA_W-1:0]  In_Data,
  input  logic               In_Valid,
  input  logic               In_Last,
  output logic               In_Ready,
  input  logic               Abort,
  output logic [DATA_W-1:0]  Out_Sum,
  output logic [CARRY_W-1:0] Out_Carries,
  output logic [CNT_W-1:0]   Out_Count,
  output logic               Out_Valid,
  input  logic               Out_Ready
);

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [CARRY_W-1:0]  carryCnt_q, carryCnt_d;
  logic [CNT_W-1:0]    beatCnt_q, beatCnt_d;

  logic                beatAccept;
  logic [DATA_W-1:0]   addSum;
  logic                addCout;

  assign In_Ready   = (state_q != DONE);
  assign beatAccept = In_Valid & In_Ready;

  CLA_Adder_dat uAdder (
    .A     (acc_q),
    .B     (In_Data),
    .C_In  (1'b0),
    .Sum   (addSum),
    .C_Out (addCout)
  );

  // Accumulator stays zero in IDLE, so the first beat simply passes through the adder.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    carryCnt_d = carryCnt_q;
    beatCnt_d  = beatCnt_q;
    if (Abort) begin
      state_d    = IDLE;
      acc_d      = '0;
      carryCnt_d = '0;
      beatCnt_d  = '0;
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          if (beatAccept) begin
            acc_d = addSum;
            if (addCout && (carryCnt_q != {CARRY_W{1'b1}}))
              carryCnt_d = carryCnt_q + CARRY_W'(1);
            if (beatCnt_q != {CNT_W{1'b1}})
              beatCnt_d = beatCnt_q + CNT_W'(1);
            state_d = In_Last ? DONE : ACCUM;
          end
        end
        DONE: begin
          if (Out_Ready) begin
            state_d    = IDLE;
            acc_d      = '0;
            carryCnt_d = '0;
            beatCnt_d  = '0;
          end
        end
        default: begin
          state_d    = IDLE;
          acc_d      = '0;
          carryCnt_d = '0;
          beatCnt_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      carryCnt_q <= '0;
      beatCnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      carryCnt_q <= carryCnt_d;
      beatCnt_q  <= beatCnt_d;
    end
  end

  assign Out_Valid   = (state_q == DONE);
  assign Out_Sum     = Out_Valid ? acc_q      : '0;
  assign Out_Carries = Out_Valid ? carryCnt_q : '0;
  assign Out_Count   = Out_Valid ? beatCnt_q  : '0;

endmodule

// File: tb/tb_cla_accumulator.sv
// Scoreboard bench for cla_accumulator: a reference model pushes the expected
// group result on each last beat, and each scenario pops and compares it.
module tb_cla_accumulator;

  localparam int CNT_W = 8;

  typedef struct packed {
    logic [15:0]      sum;
    logic [3:0]       carries;
    logic [CNT_W-1:0] count;
  } res_t;

  logic             Clk = 1'b0;
  logic             Reset;
  logic [15:0]      In_Data;
  logic             In_Valid;
  logic             In_Last;
  logic             In_Ready;
  logic             Abort;
  logic [15:0]      Out_Sum;
  logic [3:0]       Out_Carries;
  logic [CNT_W-1:0] Out_Count;
  logic             Out_Valid;
  logic             Out_Ready;

  int compared   = 0;
  int mismatched = 0;

  res_t             sbQ[$];
  res_t             expRes;
  res_t             obs;
  logic [15:0]      modelSum     = '0;
  logic [3:0]       modelCarries = '0;
  logic [CNT_W-1:0] modelCount   = '0;

  cla_accumulator #(.CNT_W(CNT_W)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .In_Data     (In_Data),
    .In_Valid    (In_Valid),
    .In_Last     (In_Last),
    .In_Ready    (In_Ready),
    .Abort       (Abort),
    .Out_Sum     (Out_Sum),
    .Out_Carries (Out_Carries),
    .Out_Count   (Out_Count),
    .Out_Valid   (Out_Valid),
    .Out_Ready   (Out_Ready)
  );

  always #5 Clk = ~Clk;

  // Drives one beat from a falling edge and returns on the next falling edge.
  task automatic sendBeat(input logic [15:0] d, input logic last);
    logic [16:0] s17;
    In_Valid = 1'b1;
    In_Data  = d;
    In_Last  = last;
    @(posedge Clk);
    s17 = {1'b0, modelSum} + {1'b0, d};
    modelSum = s17[15:0];
    if (s17[16] && modelCarries != 4'hF) modelCarries = modelCarries + 4'd1;
    if (modelCount != {CNT_W{1'b1}}) modelCount = modelCount + CNT_W'(1);
    if (last) begin
      sbQ.push_back({modelSum, modelCarries, modelCount});
      modelSum = '0; modelCarries = '0; modelCount = '0;
    end
    @(negedge Clk);
    In_Valid = 1'b0;
    In_Last  = 1'b0;
  endtask

  task automatic modelClear();
    modelSum = '0; modelCarries = '0; modelCount = '0;
  endtask

  task automatic releaseResult();
    Out_Ready = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    Out_Ready = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    obs = {Out_Sum, Out_Carries, Out_Count};
    compared++; if (Out_Valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %b expected 0", Out_Valid); end
    compared++; if (In_Ready !== 1'b1) begin mismatched++; $display("FAIL reset_ready: got %b expected 1", In_Ready); end
    compared++; if (obs !== '0) begin mismatched++; $display("FAIL reset_outputs: got %h expected 0", obs); end
  endtask

  task automatic test_basic();
    sendBeat(16'h0001, 1'b0);
    sendBeat(16'h0002, 1'b0);
    sendBeat(16'h0003, 1'b1);
    expRes = sbQ.pop_front();
    obs = {Out_Sum, Out_Carries, Out_Count};
    compared++; if (Out_Valid !== 1'b1) begin mismatched++; $display("FAIL basic_latency: Out_Valid got %b expected 1", Out_Valid); end
    compared++; if (obs !== expRes) begin mismatched++; $display("FAIL basic_result: got %h expected %h", obs, expRes); end
    compared++; if (Out_Sum !== 16'h0006) begin mismatched++; $display("FAIL basic_sum: got %h expected 0006", Out_Sum); end
    releaseResult();
    obs = {Out_Sum, Out_Carries, Out_Count};
    compared++; if (Out_Valid !== 1'b0) begin mismatched++; $display("FAIL basic_release: Out_Valid got %b expected 0", Out_Valid); end
    compared++; if (obs !== '0) begin mismatched++; $display("FAIL basic_zero_outputs: got %h expected 0", obs); end
    compared++; if (In_Ready !== 1'b1) begin mismatched++; $display("FAIL basic_ready: got %b expected 1", In_Ready); end
  endtask

  task automatic test_carry_wrap();
    sendBeat(16'hFFFF, 1'b0);
    sendBeat(16'h0002, 1'b1);
    expRes = sbQ.pop_front();
    obs = {Out_Sum, Out_Carries, Out_Count};
    compared++; if (obs !== expRes) begin mismatched++; $display("FAIL carry_wrap: got %h expected %h", obs, expRes); end
    releaseResult();
  endtask

  task automatic test_backpressure();
    sendBeat(16'h1234, 1'b1);
    expRes = sbQ.pop_front();
    for (int i = 0; i < 5; i++) begin
      obs = {Out_Sum, Out_Carries, Out_Count};
      compared++; if (Out_Valid !== 1'b1) begin mismatched++; $display("FAIL hold_valid[%0d]: got %b expected 1", i, Out_Valid); end
      compared++; if (obs !== expRes) begin mismatched++; $display("FAIL hold_result[%0d]: got %h expected %h", i, obs, expRes); end
      compared++; if (In_Ready !== 1'b0) begin mismatched++; $display("FAIL hold_ready[%0d]: got %b expected 0", i, In_Ready); end
      @(posedge Clk);
      @(negedge Clk);
    end
    releaseResult();
    compared++; if (Out_Valid !== 1'b0) begin mismatched++; $display("FAIL hold_release: Out_Valid got %b expected 0", Out_Valid); end
    compared++; if (In_Ready !== 1'b1) begin mismatched++; $display("FAIL hold_idle_ready: got %b expected 1", In_Ready); end
  endtask

  task automatic test_carry_saturation();
    for (int i = 0; i < 16; i++) sendBeat(16'hFFFF, 1'b0);
    sendBeat(16'hFFFF, 1'b1);
    expRes = sbQ.pop_front();
    obs = {Out_Sum, Out_Carries, Out_Count};
    compared++; if (obs !== expRes) begin mismatched++; $display("FAIL carry_saturation: got %h expected %h", obs, expRes); end
    compared++; if (Out_Carries !== 4'd15) begin mismatched++; $display("FAIL carry_sat_value: got %0d expected 15", Out_Carries); end
    releaseResult();
  endtask

  task automatic test_count_saturation();
    for (int i = 0; i < 259; i++) sendBeat(16'h0001, 1'b0);
    sendBeat(16'h0001, 1'b1);
    expRes = sbQ.pop_front();
    obs = {Out_Sum, Out_Carries, Out_Count};
    compared++; if (obs !== expRes) begin mismatched++; $display("FAIL count_saturation: got %h expected %h", obs, expRes); end
    releaseResult();
  endtask

  task automatic test_abort();
    sendBeat(16'h0010, 1'b0);
    sendBeat(16'h0020, 1'b0);
    Abort    = 1'b1;
    In_Valid = 1'b1;
    In_Data  = 16'h7777;
    @(posedge Clk);
    modelClear();
    @(negedge Clk);
    Abort    = 1'b0;
    In_Valid = 1'b0;
    compared++; if (Out_Valid !== 1'b0) begin mismatched++; $display("FAIL abort_valid: got %b expected 0", Out_Valid); end
    compared++; if (In_Ready !== 1'b1) begin mismatched++; $display("FAIL abort_ready: got %b expected 1", In_Ready); end
    sendBeat(16'h0005, 1'b1);
    expRes = sbQ.pop_front();
    obs = {Out_Sum, Out_Carries, Out_Count};
    compared++; if (obs !== expRes) begin mismatched++; $display("FAIL abort_next_group: got %h expected %h", obs, expRes); end
    // Abort in DONE discards the pending result
    Abort = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    Abort = 1'b0;
    compared++; if (Out_Valid !== 1'b0) begin mismatched++; $display("FAIL abort_in_done: Out_Valid got %b expected 0", Out_Valid); end
  endtask

  task automatic test_back_to_back();
    sendBeat(16'h0001, 1'b1);
    expRes = sbQ.pop_front();
    obs = {Out_Sum, Out_Carries, Out_Count};
    compared++; if (obs !== expRes) begin mismatched++; $display("FAIL b2b_first: got %h expected %h", obs, expRes); end
    Out_Ready = 1'b1;
    In_Valid  = 1'b1;
    In_Data   = 16'h0099;
    In_Last   = 1'b1;
    compared++; if (In_Ready !== 1'b0) begin mismatched++; $display("FAIL b2b_ready_in_done: got %b expected 0", In_Ready); end
    @(posedge Clk);
    @(negedge Clk);
    Out_Ready = 1'b0;
    compared++; if (Out_Valid !== 1'b0) begin mismatched++; $display("FAIL b2b_valid_drop: got %b expected 0", Out_Valid); end
    sendBeat(16'h0099, 1'b1);
    expRes = sbQ.pop_front();
    obs = {Out_Sum, Out_Carries, Out_Count};
    compared++; if (obs !== expRes) begin mismatched++; $display("FAIL b2b_second: got %h expected %h", obs, expRes); end
    releaseResult();
  endtask

  task automatic test_reset_in_done();
    sendBeat(16'hABCD, 1'b1);
    expRes = sbQ.pop_front();
    compared++; if (Out_Valid !== 1'b1) begin mismatched++; $display("FAIL rst_done_pre: Out_Valid got %b expected 1", Out_Valid); end
    Reset     = 1'b1;
    Out_Ready = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    Reset     = 1'b0;
    Out_Ready = 1'b0;
    obs = {Out_Sum, Out_Carries, Out_Count};
    compared++; if (Out_Valid !== 1'b0) begin mismatched++; $display("FAIL rst_done_valid: got %b expected 0", Out_Valid); end
    compared++; if (obs !== '0) begin mismatched++; $display("FAIL rst_done_outputs: got %h expected 0", obs); end
    compared++; if (In_Ready !== 1'b1) begin mismatched++; $display("FAIL rst_done_ready: got %b expected 1", In_Ready); end
    // Reset mid-group drops the partial accumulation
    sendBeat(16'h0100, 1'b0);
    Reset = 1'b1;
    @(posedge Clk);
    modelClear();
    @(negedge Clk);
    Reset = 1'b0;
    sendBeat(16'h0002, 1'b1);
    expRes = sbQ.pop_front();
    obs = {Out_Sum, Out_Carries, Out_Count};
    compared++; if (obs !== expRes) begin mismatched++; $display("FAIL rst_mid_group: got %h expected %h", obs, expRes); end
    releaseResult();
  endtask

  initial begin
    Reset     = 1'b1;
    In_Data   = '0;
    In_Valid  = 1'b0;
    In_Last   = 1'b0;
    Abort     = 1'b0;
    Out_Ready = 1'b0;
    @(negedge Clk);
    test_reset();
    test_basic();
    test_carry_wrap();
    test_backpressure();
    test_carry_saturation();
    test_count_saturation();
    test_abort();
    test_back_to_back();
    test_reset_in_done();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
